// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the big-endian load/store unit.
// Holds access-size encodings, FSM states, write masks and the fault rule.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Big-endian: a sub-word access always lands in the most significant lanes.
    localparam logic [31:0] MASK_NONE = 32'h0000_0000;
    localparam logic [31:0] MASK_BYTE = 32'hFF00_0000;
    localparam logic [31:0] MASK_HALF = 32'hFFFF_0000;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    function automatic logic [31:0] size_mask(input lsu_size_e size);
        case (size)
            SIZE_BYTE: return MASK_BYTE;
            SIZE_HALF: return MASK_HALF;
            SIZE_WORD: return MASK_WORD;
            default:   return MASK_NONE;
        endcase
    endfunction

    // The range limit applies to every size, so even a byte access near the top faults.
    function automatic logic access_fault(input lsu_size_e   size,
                                          input logic [31:0] addr,
                                          input logic [31:0] max_addr);
        logic misaligned;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            SIZE_WORD: misaligned = |addr[1:0];
            default:   misaligned = 1'b1;
        endcase
        return misaligned || (addr > max_addr);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: extracts and extends loaded sub-words and merges
// store data into the top lanes of a previously read word.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    always_comb begin
        load_data  = 32'h0;
        store_data = rdata;
        case (size)
            SIZE_BYTE: begin
                load_data  = {{24{is_signed & rdata[31]}}, rdata[31:24]};
                store_data = {wdata[7:0], rdata[23:0]};
            end
            SIZE_HALF: begin
                load_data  = {{16{is_signed & rdata[31]}}, rdata[31:16]};
                store_data = {wdata[15:0], rdata[15:0]};
            end
            SIZE_WORD: begin
                load_data  = rdata;
                store_data = wdata;
            end
            default: begin
                load_data  = 32'h0;
                store_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a big-endian byte memory; sub-word
// stores use read-modify-write so only the addressed top lanes change.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_mask,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    lsu_size_e   size_q, size_d;
    logic        signed_q, signed_d;
    logic        store_q, store_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] mem_mask_q, mem_mask_d;

    lsu_size_e   req_size_e;
    logic [31:0] load_word;
    logic [31:0] merged_word;

    assign req_size_e = lsu_size_e'(req_size);

    lsu_align u_align (
        .size       (size_q),
        .is_signed  (signed_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_word),
        .store_data (merged_word)
    );

    // Memory-port and response outputs are computed one state ahead so they
    // come straight from flops while the FSM sits in the matching state.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        store_d      = store_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_fault_d = 1'b0;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        mem_mask_d   = MASK_NONE;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size_e;
                    signed_d = req_signed;
                    store_d  = req_store;
                    if (access_fault(req_size_e, req_addr, MAX_ADDR)) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (req_store && req_size_e == SIZE_WORD) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        mem_mask_d  = MASK_WORD;
                    end else begin
                        state_d    = READ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = req_addr;
                    end
                end
            end
            READ: begin
                if (store_q) begin
                    state_d     = WRITE;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = merged_word;
                    mem_mask_d  = size_mask(size_q);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_word;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = resp_rdata_q;
                    resp_fault_d = resp_fault_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            store_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_mask_q   <= MASK_NONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            store_q      <= store_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
        end
    end

    // Reset masks the flops immediately so a write in flight never lands.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q && !rst;
    assign resp_rdata = rst ? 32'h0 : resp_rdata_q;
    assign resp_fault = resp_fault_q && !rst;
    assign mem_rd     = mem_rd_q && !rst;
    assign mem_wr     = mem_wr_q && !rst;
    assign mem_addr   = rst ? 32'h0 : mem_addr_q;
    assign mem_wdata  = rst ? 32'h0 : mem_wdata_q;
    assign mem_mask   = rst ? MASK_NONE : mem_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// each response, a monitor compares whatever the DUT presents.
module tb_load_store_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_mask;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] mask;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];

    logic [7:0] phys_mem [0:MEM_BYTES-1] = '{default: 8'h00};
    logic [7:0] ref_mem  [0:MEM_BYTES-1] = '{default: 8'h00};

    logic        poke_en;
    logic [31:0] poke_addr;
    logic [31:0] poke_data;
    int          rr_mode;
    int          cyc;
    int          checks;
    int          errors;

    int          acc_cyc;
    int          n_rd;
    int          n_wr;
    bit          resp_seen;
    logic [31:0] hold_rdata;
    logic        hold_fault;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached memory: big-endian word view of a byte array, lane-masked writes.
    always_comb begin
        mem_rdata = 32'h0;
        for (int k = 0; k < 4; k++)
            mem_rdata[31-8*k -: 8] = phys_mem[int'((mem_addr + 32'(k)) % 32'(MEM_BYTES))];
    end

    always @(posedge clk) begin
        if (mem_wr)
            for (int k = 0; k < 4; k++)
                if (mem_mask[31-8*k])
                    phys_mem[int'((mem_addr + 32'(k)) % 32'(MEM_BYTES))] <= mem_wdata[31-8*k -: 8];
        if (poke_en)
            for (int k = 0; k < 4; k++)
                phys_mem[int'((poke_addr + 32'(k)) % 32'(MEM_BYTES))] <= poke_data[31-8*k -: 8];
    end

    always @(posedge clk) begin
        #1;
        if (rr_mode == 1)
            resp_ready = ($urandom_range(0, 2) != 0);
        else if (rr_mode == 0)
            resp_ready = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks memory activity per transaction and checks each response.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd || mem_wr) begin
                checkOutput("mem_rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'h0);
                if (sb.size() > 0) begin
                    checkOutput("mem_addr", mem_addr, sb[0].addr);
                    if (mem_wr) checkOutput("mem_mask", mem_mask, sb[0].mask);
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc   = cyc;
                n_rd      = 0;
                n_wr      = 0;
                resp_seen = 1'b0;
            end else begin
                n_rd += int'(mem_rd);
                n_wr += int'(mem_wr);
            end
            if (resp_valid) begin
                checkOutput("req_ready_while_resp", {31'b0, req_ready}, 32'h0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_resp: got resp_valid=1 expected no pending request");
                end else if (!resp_seen) begin
                    checkOutput("latency", acc_cyc >= 0 ? 32'(cyc - acc_cyc) : 32'hFFFF_FFFF, 32'(sb[0].lat));
                    checkOutput("resp_rdata", resp_rdata, sb[0].rdata);
                    checkOutput("resp_fault", {31'b0, resp_fault}, {31'b0, sb[0].fault});
                    checkOutput("mem_rd_cycles", 32'(n_rd), 32'(sb[0].n_rd));
                    checkOutput("mem_wr_cycles", 32'(n_wr), 32'(sb[0].n_wr));
                    checkOutput("resp_mem_idle", mem_addr | mem_mask, 32'h0);
                    hold_rdata = resp_rdata;
                    hold_fault = resp_fault;
                    resp_seen  = 1'b1;
                end else begin
                    checkOutput("resp_rdata_stable", resp_rdata, hold_rdata);
                    checkOutput("resp_fault_stable", {31'b0, resp_fault}, {31'b0, hold_fault});
                end
                if (resp_ready && sb.size() > 0) begin
                    void'(sb.pop_front());
                    resp_seen = 1'b0;
                end
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = d[31-8*k -: 8];
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Issues one request, waits (bounded) for acceptance and records the
    // response the reference model predicts for it.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd);
        exp_t   e;
        bit     got;
        int     nbytes;
        longint v;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got req_ready=0 expected acceptance within 50 cycles");
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            return;
        end
        nbytes = (sz == 2'd3) ? 0 : (1 << sz);
        e.addr = a;
        e.mask = (nbytes == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - 8 * nbytes));
        if (nbytes == 0 || (a % nbytes) != 0 || longint'(a) + 4 > longint'(MEM_BYTES)) begin
            e.rdata = 32'h0; e.fault = 1'b1; e.lat = 1; e.n_rd = 0; e.n_wr = 0;
        end else if (st) begin
            for (int k = 0; k < nbytes; k++)
                ref_mem[int'(a) + k] = 8'(wd >> (8 * (nbytes - 1 - k)));
            e.rdata = 32'h0; e.fault = 1'b0;
            e.lat   = (nbytes == 4) ? 2 : 3;
            e.n_rd  = (nbytes == 4) ? 0 : 1;
            e.n_wr  = 1;
        end else begin
            v = 0;
            for (int k = 0; k < nbytes; k++) v = v * 256 + longint'(ref_mem[int'(a) + k]);
            if (sg && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v -= (longint'(1) << (8 * nbytes));
            e.rdata = v[31:0]; e.fault = 1'b0; e.lat = 2; e.n_rd = 1; e.n_wr = 0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic waitIdle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && req_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected completion before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          got;
        logic [1:0]  sz;
        logic [31:0] a;
        int          diff;
        checks = 0; errors = 0; cyc = 0; acc_cyc = -1; n_rd = 0; n_wr = 0;
        resp_seen = 1'b0; hold_rdata = 32'h0; hold_fault = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1; rr_mode = 0;
        poke_en = 1'b0; poke_addr = 32'h0; poke_data = 32'h0;

        // Outputs are quiet throughout reset and the unit is ready right after.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h0);
        checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("reset_resp_fault", {31'b0, resp_fault}, 32'h0);
        checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset_mem_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset_mem_mask", mem_mask, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Sub-word loads from a preloaded word.
        poke(32'h10, 32'h8091_A2B3);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);

        // Word store, byte read-modify-write, halfword store.
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0012);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_5A6B);
        applyStimulus(1'b0, 2'd2, 1'b1, 32'h20, 32'h0);

        // Faults and the top-of-memory boundary.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h13, 32'h1234);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h3FD, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h3FD, 32'h0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFE_F00D);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h3FC, 32'h0);

        // Response back-pressure: held for five cycles, taken on the sixth.
        waitIdle();
        rr_mode = 2;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        checkOutput("hold_resp_seen", {31'b0, got}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("hold_resp_valid", {31'b0, resp_valid}, 32'h1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_sixth_valid", {31'b0, resp_valid}, 32'h1);
        @(posedge clk);
        #1;
        rr_mode = 0;
        @(negedge clk);
        checkOutput("idle_after_handshake", {30'b0, req_ready, resp_valid}, 32'h2);
        @(posedge clk);
        #1;

        // Reset during the write phase of a byte read-modify-write.
        waitIdle();
        poke(32'h30, 32'h1122_3344);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h30, 32'h0000_00AA);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_wr) got = 1'b1;
        end
        checkOutput("rmw_write_seen", {31'b0, got}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_wr", {31'b0, mem_wr}, 32'h0);
        checkOutput("abort_flags", {28'b0, req_ready, resp_valid, resp_fault, mem_rd}, 32'h0);
        checkOutput("abort_data", mem_addr | mem_wdata | mem_mask | resp_rdata, 32'h0);
        sb.delete();
        ref_mem[32'h30] = 8'h11;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_abort", {31'b0, req_ready}, 32'h1);
        checkOutput("mem_after_abort",
                    {phys_mem[32'h30], phys_mem[32'h31], phys_mem[32'h32], phys_mem[32'h33]},
                    32'h1122_3344);
        @(posedge clk);
        #1;

        // Randomized traffic with random response back-pressure.
        rr_mode = 1;
        for (int n = 0; n < 150; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       a = 32'(MEM_BYTES - 8) + 32'($urandom_range(0, 7));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 127));
            endcase
            if (sz != 2'd3 && $urandom_range(0, 4) != 0)
                a = a & ~((32'h1 << sz) - 32'h1);
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        rr_mode = 0;
        waitIdle();

        diff = 0;
        for (int i = 0; i < MEM_BYTES; i++)
            if (phys_mem[i] !== ref_mem[i]) diff++;
        checkOutput("mem_image_diff_bytes", 32'(diff), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
